// File: rtl/alu_cmd_ctrl.sv
// Command/response controller wrapped around a combinational ALU: accepts a
// command, drives registered ALU operands, captures the result and holds it until consumed.
module alu_cmd_ctrl #(
  parameter int unsigned bits = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_op,
  input  logic [bits-1:0] cmd_a,
  input  logic [bits-1:0] cmd_b,
  input  logic            cmd_flag,
  output logic [bits-1:0] ALUA,
  output logic [bits-1:0] ALUB,
  output logic            ALUFlagIn,
  output logic [3:0]      ALUControl,
  input  logic [bits-1:0] ALUResult,
  input  logic            ALUFlags,
  input  logic            C,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [bits-1:0] rsp_result,
  output logic            rsp_flag,
  output logic            rsp_carry,
  output logic [3:0]      rsp_op,
  output logic            rsp_err,
  output logic            busy,
  output logic [7:0]      rsp_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] OP_LAST = 4'hC;

  state_e          state_q, state_d;
  logic [bits-1:0] alua_q, alua_d;
  logic [bits-1:0] alub_q, alub_d;
  logic            alu_flag_in_q, alu_flag_in_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  logic [bits-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_flag_q, rsp_flag_d;
  logic            rsp_carry_q, rsp_carry_d;
  logic [3:0]      rsp_op_q, rsp_op_d;
  logic            rsp_err_q, rsp_err_d;
  logic [7:0]      rsp_count_q, rsp_count_d;

  always_comb begin
    state_d       = state_q;
    alua_d        = alua_q;
    alub_d        = alub_q;
    alu_flag_in_d = alu_flag_in_q;
    alu_ctrl_d    = alu_ctrl_q;
    rsp_result_d  = rsp_result_q;
    rsp_flag_d    = rsp_flag_q;
    rsp_carry_d   = rsp_carry_q;
    rsp_op_d      = rsp_op_q;
    rsp_err_d     = rsp_err_q;
    rsp_count_d   = rsp_count_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alua_d        = cmd_a;
          alub_d        = cmd_b;
          alu_flag_in_d = cmd_flag;
          alu_ctrl_d    = cmd_op;
          rsp_op_d      = cmd_op;
          // Illegal opcodes bypass EXEC and answer immediately with a zeroed result.
          if (cmd_op > OP_LAST) begin
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_flag_d   = 1'b0;
            rsp_carry_d  = 1'b0;
            state_d      = RESP;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        rsp_result_d = ALUResult;
        rsp_flag_d   = ALUFlags;
        rsp_carry_d  = C;
        rsp_err_d    = 1'b0;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_count_d = rsp_count_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      alua_q        <= '0;
      alub_q        <= '0;
      alu_flag_in_q <= 1'b0;
      alu_ctrl_q    <= '0;
      rsp_result_q  <= '0;
      rsp_flag_q    <= 1'b0;
      rsp_carry_q   <= 1'b0;
      rsp_op_q      <= '0;
      rsp_err_q     <= 1'b0;
      rsp_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      alua_q        <= alua_d;
      alub_q        <= alub_d;
      alu_flag_in_q <= alu_flag_in_d;
      alu_ctrl_q    <= alu_ctrl_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flag_q    <= rsp_flag_d;
      rsp_carry_q   <= rsp_carry_d;
      rsp_op_q      <= rsp_op_d;
      rsp_err_q     <= rsp_err_d;
      rsp_count_q   <= rsp_count_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign ALUA       = alua_q;
  assign ALUB       = alub_q;
  assign ALUFlagIn  = alu_flag_in_q;
  assign ALUControl = alu_ctrl_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flag   = rsp_flag_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_count  = rsp_count_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl with a reference 8-bit ALU in the loop
// and a scoreboard of expected responses.
module tb_alu_cmd_ctrl;

  typedef struct packed {
    logic [3:0] op;
    logic       err;
    logic       flag;
    logic       carry;
    logic [7:0] result;
  } exp_t;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready, cmd_flag;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [7:0] ALUA, ALUB, ALUResult;
  logic       ALUFlagIn, ALUFlags, C;
  logic [3:0] ALUControl;
  logic       rsp_valid, rsp_ready, rsp_flag, rsp_carry, rsp_err, busy;
  logic [7:0] rsp_result, rsp_count;
  logic [3:0] rsp_op;

  int   checks = 0;
  int   failures = 0;
  int   exp_count = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t rsp_pack;

  // Reference ALU: returns {carry, zero, result}
  function automatic logic [9:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic f);
    logic [8:0] t;
    t = '0;
    case (op)
      4'h0: t = {1'b0, a & b};
      4'h1: t = {1'b0, a | b};
      4'h2: t = {1'b0, a ^ b};
      4'h3: t = {1'b0, a} + {1'b0, b};
      4'h4: t = {1'b0, a} - {1'b0, b};
      4'h5: t = {1'b0, a} + {1'b0, b} + {8'd0, f};
      4'h6: t = {1'b0, ~a};
      4'h7: t = {a, 1'b0};
      4'h8: t = {a[0], 1'b0, a[7:1]};
      4'h9: t = {1'b0, b};
      4'hA: t = {1'b0, f ? b : a};
      4'hB: t = {1'b0, (a > b) ? a : b};
      4'hC: t = {1'b0, (a < b) ? a : b};
      default: t = '0;
    endcase
    return {t[8], (t[7:0] == 8'h00), t[7:0]};
  endfunction

  function automatic exp_t make_exp(input logic [3:0] op, input logic [7:0] a,
                                    input logic [7:0] b, input logic f);
    logic [9:0] r;
    exp_t       e;
    r = alu_ref(op, a, b, f);
    if (op > 4'hC) e = {op, 1'b1, 1'b0, 1'b0, 8'h00};
    else           e = {op, 1'b0, r[8], r[9], r[7:0]};
    return e;
  endfunction

  assign {C, ALUFlags, ALUResult} = alu_ref(ALUControl, ALUA, ALUB, ALUFlagIn);
  assign rsp_pack = {rsp_op, rsp_err, rsp_flag, rsp_carry, rsp_result};

  alu_cmd_ctrl #(.bits(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_flag(cmd_flag),
    .ALUA(ALUA), .ALUB(ALUB), .ALUFlagIn(ALUFlagIn), .ALUControl(ALUControl),
    .ALUResult(ALUResult), .ALUFlags(ALUFlags), .C(C),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flag(rsp_flag), .rsp_carry(rsp_carry), .rsp_op(rsp_op),
    .rsp_err(rsp_err), .busy(busy), .rsp_count(rsp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic f);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_flag = f; cmd_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ALUA, ALUB, ALUFlagIn, ALUControl} !== '0) begin
      failures++; $display("FAIL reset_alu got=%h exp=0", {ALUA, ALUB, ALUFlagIn, ALUControl});
    end
    checks++;
    if ({rsp_valid, rsp_pack, busy} !== '0) begin
      failures++; $display("FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_pack, busy});
    end
    checks++;
    if ({cmd_ready, rsp_count} !== {1'b1, 8'h00}) begin
      failures++; $display("FAIL reset_ready_count got=%h exp=100", {cmd_ready, rsp_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_and_legal();
    exp_t e;
    set_cmd(4'h0, 8'hF0, 8'h0F, 1'b0);
    sb.push_back(make_exp(4'h0, 8'hF0, 8'h0F, 1'b0));
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL first_accept_ready got=%b exp=1", cmd_ready);
    end
    @(posedge clk); #1; cmd_valid = 1'b0;
    checks++;
    if ({rsp_valid, busy} !== 2'b01) begin
      failures++; $display("FAIL and_exec valid_busy got=%b exp=01", {rsp_valid, busy});
    end
    checks++;
    if ({ALUControl, ALUA, ALUB, ALUFlagIn} !== {4'h0, 8'hF0, 8'h0F, 1'b0}) begin
      failures++; $display("FAIL and_alu_regs got=%h", {ALUControl, ALUA, ALUB, ALUFlagIn});
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++; $display("FAIL and_latency rsp_valid got=%b exp=1", rsp_valid);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_pack !== e) begin
      failures++; $display("FAIL and_rsp got=%h exp=%h", rsp_pack, e);
    end
    checks++;
    if ({rsp_op, rsp_err, rsp_result} !== {4'h0, 1'b0, 8'h00}) begin
      failures++; $display("FAIL and_const got=%h exp=000", {rsp_op, rsp_err, rsp_result});
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0; exp_count++;
    checks++;
    if ({rsp_valid, cmd_ready, rsp_count} !== {2'b01, 8'h01}) begin
      failures++; $display("FAIL and_handshake got=%h exp=101", {rsp_valid, cmd_ready, rsp_count});
    end
  endtask

  task automatic test_carry();
    exp_t e;
    set_cmd(4'h3, 8'hFF, 8'h01, 1'b0);
    sb.push_back(make_exp(4'h3, 8'hFF, 8'h01, 1'b0));
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_pack} !== {1'b1, e}) begin
      failures++; $display("FAIL carry_rsp got=%h exp=%h", {rsp_valid, rsp_pack}, {1'b1, e});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rsp_carry, rsp_result, rsp_carry == C} !== {1'b1, 8'h00, 1'b1}) begin
      failures++; $display("FAIL carry_latched carry=%b result=%h alu_c=%b exp carry=1 result=00",
                           rsp_carry, rsp_result, C);
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0; exp_count++;
    checks++;
    if (rsp_count !== 8'(exp_count)) begin
      failures++; $display("FAIL carry_count got=%0d exp=%0d", rsp_count, exp_count);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    set_cmd(4'hE, 8'h12, 8'h34, 1'b1);
    sb.push_back(make_exp(4'hE, 8'h12, 8'h34, 1'b1));
    @(posedge clk); #1; cmd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++; $display("FAIL illegal_latency rsp_valid got=%b exp=1", rsp_valid);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_pack !== e) begin
      failures++; $display("FAIL illegal_rsp got=%h exp=%h", rsp_pack, e);
    end
    checks++;
    if ({rsp_err, rsp_result, ALUControl, ALUA} !== {1'b1, 8'h00, 4'hE, 8'h12}) begin
      failures++; $display("FAIL illegal_fields got=%h", {rsp_err, rsp_result, ALUControl, ALUA});
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0; exp_count++;
    checks++;
    if ({cmd_ready, rsp_count} !== {1'b1, 8'(exp_count)}) begin
      failures++; $display("FAIL illegal_handshake got=%h exp count=%0d", {cmd_ready, rsp_count}, exp_count);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    set_cmd(4'h1, 8'h5A, 8'h0F, 1'b0);
    sb.push_back(make_exp(4'h1, 8'h5A, 8'h0F, 1'b0));
    @(posedge clk); #1;
    set_cmd(4'h2, 8'hC3, 8'h3C, 1'b1);
    @(posedge clk); #1;
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, cmd_ready, rsp_pack} !== {2'b10, e}) begin
        failures++; $display("FAIL bp_rsp_hold cyc=%0d got=%h exp=%h", i, {rsp_valid, cmd_ready, rsp_pack}, {2'b10, e});
      end
      checks++;
      if ({ALUControl, ALUA, ALUB, ALUFlagIn} !== {4'h1, 8'h5A, 8'h0F, 1'b0}) begin
        failures++; $display("FAIL bp_alu_hold cyc=%0d got=%h", i, {ALUControl, ALUA, ALUB, ALUFlagIn});
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0; exp_count++;
    checks++;
    if ({cmd_ready, rsp_count} !== {1'b1, 8'(exp_count)}) begin
      failures++; $display("FAIL bp_release got=%h exp count=%0d", {cmd_ready, rsp_count}, exp_count);
    end
    sb.push_back(make_exp(4'h2, 8'hC3, 8'h3C, 1'b1));
    @(posedge clk); #1; cmd_valid = 1'b0;
    checks++;
    if ({busy, ALUControl, ALUA, ALUB, ALUFlagIn} !== {1'b1, 4'h2, 8'hC3, 8'h3C, 1'b1}) begin
      failures++; $display("FAIL bp_next_accept got=%h", {busy, ALUControl, ALUA, ALUB, ALUFlagIn});
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_pack} !== {1'b1, e}) begin
      failures++; $display("FAIL bp_next_rsp got=%h exp=%h", {rsp_valid, rsp_pack}, {1'b1, e});
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0; exp_count++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [6];
    int         acc_cyc, prev_cyc, t;
    logic       prev_legal;
    exp_t       e;
    logic [7:0] a, b;
    ops = '{4'h3, 4'hD, 4'h4, 4'hF, 4'hC, 4'hB};
    rsp_ready = 1'b1;
    prev_cyc = 0; prev_legal = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(255)); b = 8'($urandom_range(255));
      set_cmd(ops[i], a, b, 1'b0);
      t = 0;
      while (!cmd_ready && t < 10) begin @(posedge clk); #1; t++; end
      @(posedge clk); acc_cyc = cyc; #1;
      sb.push_back(make_exp(ops[i], a, b, 1'b0));
      if (i > 0) begin
        checks++;
        if (acc_cyc - prev_cyc != (prev_legal ? 3 : 2)) begin
          failures++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=%0d", i, acc_cyc - prev_cyc, prev_legal ? 3 : 2);
        end
      end
      prev_cyc = acc_cyc; prev_legal = (ops[i] <= 4'hC);
      t = 0;
      while (!rsp_valid && t < 10) begin @(posedge clk); #1; t++; end
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_pack} !== {1'b1, e}) begin
        failures++; $display("FAIL b2b_rsp idx=%0d got=%h exp=%h", i, {rsp_valid, rsp_pack}, {1'b1, e});
      end
      @(posedge clk); #1; exp_count++;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (rsp_count !== 8'(exp_count)) begin
      failures++; $display("FAIL b2b_count got=%0d exp=%0d", rsp_count, exp_count);
    end
  endtask

  task automatic test_reset_in_exec();
    set_cmd(4'h4, 8'h0A, 8'h05, 1'b0);
    sb.push_back(make_exp(4'h4, 8'h0A, 8'h05, 1'b0));
    @(posedge clk); #1; cmd_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    exp_count = 0;
    checks++;
    if ({busy, cmd_ready, rsp_valid} !== 3'b010) begin
      failures++; $display("FAIL rst_exec_state got=%b exp=010", {busy, cmd_ready, rsp_valid});
    end
    checks++;
    if ({ALUA, ALUB, ALUFlagIn, ALUControl, rsp_pack, rsp_count} !== '0) begin
      failures++; $display("FAIL rst_exec_outputs got=%h exp=0", {ALUA, ALUB, ALUFlagIn, ALUControl, rsp_pack, rsp_count});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_count} !== {1'b0, 8'h00}) begin
        failures++; $display("FAIL rst_exec_no_rsp cyc=%0d got=%h exp=000", i, {rsp_valid, rsp_count});
      end
    end
  endtask

  task automatic test_wrap();
    exp_t       e;
    int         t;
    logic [3:0] op;
    logic [7:0] a, b;
    rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      op = 4'(i % 16); a = 8'($urandom_range(255)); b = 8'($urandom_range(255));
      set_cmd(op, a, b, 1'(i / 16));
      t = 0;
      while (!cmd_ready && t < 10) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1; cmd_valid = 1'b0;
      sb.push_back(make_exp(op, a, b, 1'(i / 16)));
      t = 0;
      while (!rsp_valid && t < 10) begin @(posedge clk); #1; t++; end
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_pack} !== {1'b1, e}) begin
        failures++; $display("FAIL wrap_rsp idx=%0d got=%h exp=%h", i, {rsp_valid, rsp_pack}, {1'b1, e});
      end
      if (i == 255) begin
        checks++;
        if (rsp_count !== 8'hFF) begin
          failures++; $display("FAIL wrap_pre_count got=%0d exp=255", rsp_count);
        end
      end
      @(posedge clk); #1; exp_count = (exp_count + 1) % 256;
    end
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_count, 8'(exp_count)} !== 16'h0000) begin
      failures++; $display("FAIL wrap_count got=%0d exp=0", rsp_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_and_legal();
    test_carry();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_in_exec();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 Parameter: bits, default 8, datapath width of the operands and result.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  controller can accept a command.
REQ-006 cmd_op  input  4  ALU opcode (0x0 AND ... 0xC MIN).
REQ-007 cmd_a, cmd_b  input  bits  operands.
REQ-008 cmd_flag  input  1  operand-select/flag input for the ALU.
REQ-009 ALUA, ALUB  output  bits  registered operands to the ALU.
REQ-010 ALUFlagIn  output  1  registered flag to the ALU.
REQ-011 ALUControl  output  4  registered opcode to the ALU.
REQ-012 ALUResult  input  bits  ALU result (combinational from the ALU).
REQ-013 ALUFlags  input  1  ALU flag output.
REQ-014 C  input  1  ALU carry output.
REQ-015 rsp_valid  output  1  response available.
REQ-016 rsp_ready  input  1  consumer accepts the response.
REQ-017 rsp_result  output  bits  captured result.
REQ-018 rsp_flag, rsp_carry  output  1 each  captured ALUFlags and C.
REQ-019 rsp_op  output  4  opcode of the command that produced this response.
REQ-020 rsp_err  output  1  opcode was illegal (0xD-0xF).
REQ-021 busy  output  1  high in any state other than IDLE.
REQ-022 rsp_count  output  8  count of completed response handshakes.

Function
REQ-023 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-024 cmd_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-025 Accept: at an edge with cmd_valid=1 and cmd_ready=1, the controller SHALL load ALUA, ALUB, ALUFlagIn and ALUControl from the cmd_* inputs and latch cmd_op into rsp_op.
REQ-026 On accept with a legal opcode (0x0-0xC), the FSM SHALL go IDLE->EXEC.
REQ-027 On accept with an illegal opcode (0xD-0xF), the FSM SHALL go IDLE->RESP, with rsp_err=1, rsp_result=0, rsp_flag=0 and rsp_carry=0; the EXEC state is skipped.
REQ-028 EXEC SHALL last exactly one cycle. At the edge leaving EXEC, the controller SHALL capture ALUResult, ALUFlags and C into rsp_result, rsp_flag and rsp_carry, set rsp_err=0, and go to RESP.
REQ-029 Latency, legal command: accept at edge k -> rsp_valid=1 after edge k+2.
REQ-030 Latency, illegal command: accept at edge k -> rsp_valid=1 after edge k+1.
REQ-031 In RESP, all rsp_* outputs SHALL hold stable until the edge where rsp_ready=1.
- At that edge the FSM SHALL go to IDLE.
- rsp_count SHALL increment by 1, wrapping 0xFF->0x00.
REQ-032 ALU* outputs SHALL change only at an accept edge and SHALL otherwise hold their last values.
REQ-033 Commands presented outside IDLE SHALL be ignored, with no state or output change; the upstream side holds them until accepted.
REQ-034 If rsp_ready is already 1 when RESP is entered, the handshake SHALL complete at the next edge (RESP lasts one cycle minimum).
REQ-035 Back-to-back commands: with rsp_ready held at 1, accepts SHALL occur at most once every 3 cycles for legal opcodes and once every 2 cycles for illegal opcodes.

Reset
REQ-036 While rst_n=0, the controller SHALL immediately, without waiting for a clock edge:
- set the state to IDLE;
- drive all ALU* outputs to 0;
- drive all rsp_* outputs to 0;
- set rsp_count=0, busy=0 and cmd_ready=1 (cmd_ready follows the IDLE state).
REQ-037 A reset asserted in EXEC or RESP SHALL abort the operation: no response is produced and rsp_count is not incremented.
REQ-038 After rst_n rises, the first accept SHALL be possible at the first clock edge.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- Legal op: AND, cmd_a=0xF0, cmd_b=0x0F, with a reference ALU (bits=8) -> rsp_valid 2 edges after accept, rsp_result=0x00, rsp_op=0x0, rsp_err=0, rsp_count 0->1.
- Carry: ADD, cmd_op=0x3, 0xFF+0x01 -> rsp_result=0x00, rsp_carry equals the ALU C value, latched.
- Illegal op: cmd_op=0xE -> rsp_valid 1 edge after accept, rsp_err=1, rsp_result=0x00, ALUControl=0xE.
- Backpressure: rsp_ready=0 for 5 cycles in RESP while cmd_valid=1 with new operands -> rsp_* and ALU* stable, cmd_ready=0, no accept; rsp_ready=1 -> IDLE and the new command is accepted on the next edge.
- Reset in EXEC (SUB, 0x0A-0x05): assert rst_n=0 mid-cycle -> immediate IDLE, all outputs 0, no response, rsp_count=0.
- Wrap: 256 completed handshakes -> rsp_count returns to 0x00.
